// File: rtl/id_decode_stage_if.sv
// IF/ID -> ID/EX bundle for the decode stage: fetch register, writeback port,
// branch flush, stall request and the registered ID/EX latch.
interface id_decode_stage_if;
  logic [1:0][31:0] if_id;
  logic             branch_cond;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic             hazard;
  logic             id_ex_valid;
  logic [31:0]      id_ex_ir;
  logic [31:0]      id_ex_npc;
  logic [31:0]      id_ex_a;
  logic [31:0]      id_ex_b;
  logic [31:0]      id_ex_imm;
  logic [4:0]       id_ex_rd;

  modport master (
    output if_id, branch_cond, wb_we, wb_rd, wb_data,
    input  hazard, id_ex_valid, id_ex_ir, id_ex_npc, id_ex_a, id_ex_b, id_ex_imm, id_ex_rd
  );

  modport slave (
    input  if_id, branch_cond, wb_we, wb_rd, wb_data,
    output hazard, id_ex_valid, id_ex_ir, id_ex_npc, id_ex_a, id_ex_b, id_ex_imm, id_ex_rd
  );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I decode stage: register file with write-through bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline latch.
module id_decode_stage #(
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int unsigned REG_COUNT = 32
) (
  input logic                clk,
  input logic                reset,
  id_decode_stage_if.slave   bus
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [31:0] rf_q [REG_COUNT];

  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        wb_wr;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm;
  logic        rs1_used, rs2_used, writes_rd;

  logic        valid_q, valid_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        hazard;

  assign ir     = bus.if_id[0];
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  assign wb_wr = bus.wb_we && (bus.wb_rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_wr) begin
      rf_q[bus.wb_rd[AW-1:0]] <= bus.wb_data;
    end
  end

  // x0 is never written, so rf_q[0] stays zero and needs no special read path.
  assign rs1_val = (wb_wr && bus.wb_rd == rs1) ? bus.wb_data : rf_q[rs1[AW-1:0]];
  assign rs2_val = (wb_wr && bus.wb_rd == rs2) ? bus.wb_data : rf_q[rs2[AW-1:0]];

  always_comb begin
    imm       = '0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    writes_rd = 1'b1;
    unique case (opcode)
      OpImm, OpLoad, OpJalr: imm = {{20{ir[31]}}, ir[31:20]};
      OpStore: begin
        imm       = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        rs2_used  = 1'b1;
        writes_rd = 1'b0;
      end
      OpBranch: begin
        imm       = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        rs2_used  = 1'b1;
        writes_rd = 1'b0;
      end
      OpLui, OpAuipc: begin
        imm      = {ir[31:12], 12'b0};
        rs1_used = 1'b0;
      end
      OpJal: begin
        imm      = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        rs1_used = 1'b0;
      end
      OpReg:   rs2_used = 1'b1;
      default: ;
    endcase
  end

  // Gating on reset keeps the stall request quiet while the latch is being cleared.
  assign hazard = reset && !bus.branch_cond && valid_q && (ir_q[6:0] == OpLoad) &&
                  (rd_q != 5'd0) &&
                  ((rs1_used && rs1 == rd_q) || (rs2_used && rs2 == rd_q));

  always_comb begin
    valid_d = 1'b0;
    ir_d    = NOP_INST;
    npc_d   = '0;
    a_d     = '0;
    b_d     = '0;
    imm_d   = '0;
    rd_d    = '0;
    if (!bus.branch_cond && !hazard) begin
      valid_d = 1'b1;
      ir_d    = ir;
      npc_d   = bus.if_id[1];
      a_d     = rs1_val;
      b_d     = rs2_val;
      imm_d   = imm;
      rd_d    = writes_rd ? rd : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ir_q    <= NOP_INST;
      npc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.hazard      = hazard;
  assign bus.id_ex_valid = valid_q;
  assign bus.id_ex_ir    = ir_q;
  assign bus.id_ex_npc   = npc_q;
  assign bus.id_ex_a     = a_q;
  assign bus.id_ex_b     = b_q;
  assign bus.id_ex_imm   = imm_q;
  assign bus.id_ex_rd    = rd_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed-vector bench for id_decode_stage; expected values are hand-computed.
module tb_id_decode_stage;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  id_decode_stage_if bus ();

  id_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] Nop = 32'h0000_0013;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] npc, input logic [31:0] ir);
    bus.if_id[1] = npc;
    bus.if_id[0] = ir;
    #1;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.branch_cond = 1'b0;
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;
    drive(32'd0, Nop);

    // 1: reset
    step();
    step();
    check_eq("rst_hazard", {31'd0, bus.hazard}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.id_ex_valid}, 32'd0);
    check_eq("rst_ir", bus.id_ex_ir, 32'h13);
    check_eq("rst_npc", bus.id_ex_npc, 32'd0);
    check_eq("rst_rd", {27'd0, bus.id_ex_rd}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rel_valid", {31'd0, bus.id_ex_valid}, 32'd0);
    check_eq("rel_ir", bus.id_ex_ir, 32'h13);

    // Registers read zero after reset
    drive(32'd8, enc_r(5'd7, 5'd1, 5'd2));
    step();
    check_eq("zero_a", bus.id_ex_a, 32'd0);
    check_eq("zero_b", bus.id_ex_b, 32'd0);
    check_eq("zero_rd", {27'd0, bus.id_ex_rd}, 32'd7);
    check_eq("zero_npc", bus.id_ex_npc, 32'd8);
    check_eq("zero_valid", {31'd0, bus.id_ex_valid}, 32'd1);

    // 2: wb x1=5 then addi x2,x1,10
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    drive(32'd0, Nop);
    step();
    bus.wb_we = 1'b0;
    drive(32'd4, 32'h00A0_8113);
    step();
    check_eq("addi_a", bus.id_ex_a, 32'd5);
    check_eq("addi_imm", bus.id_ex_imm, 32'd10);
    check_eq("addi_rd", {27'd0, bus.id_ex_rd}, 32'd2);
    check_eq("addi_npc", bus.id_ex_npc, 32'd4);
    check_eq("addi_valid", {31'd0, bus.id_ex_valid}, 32'd1);
    check_eq("addi_ir", bus.id_ex_ir, 32'h00A0_8113);

    // 3: same-cycle writeback bypass
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_DEAD;
    drive(32'd12, enc_r(5'd4, 5'd3, 5'd0));
    step();
    bus.wb_we = 1'b0;
    check_eq("byp_a", bus.id_ex_a, 32'h0000_DEAD);
    check_eq("byp_b", bus.id_ex_b, 32'd0);
    check_eq("byp_rd", {27'd0, bus.id_ex_rd}, 32'd4);

    // Immediate formats
    drive(32'd16, {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011});  // sw x2,-4(x1)
    step();
    check_eq("s_imm", bus.id_ex_imm, 32'hFFFF_FFFC);
    check_eq("s_rd", {27'd0, bus.id_ex_rd}, 32'd0);
    drive(32'd20, 32'h0020_8863);                                   // beq x1,x2,+16
    step();
    check_eq("b_imm", bus.id_ex_imm, 32'd16);
    check_eq("b_rd", {27'd0, bus.id_ex_rd}, 32'd0);
    drive(32'd24, {20'hABCDE, 5'd9, 7'b0110111});                   // lui x9,0xABCDE
    step();
    check_eq("u_imm", bus.id_ex_imm, 32'hABCD_E000);
    check_eq("u_rd", {27'd0, bus.id_ex_rd}, 32'd9);
    drive(32'd28, 32'hFF9F_F0EF);                                   // jal x1,-8
    step();
    check_eq("j_imm", bus.id_ex_imm, 32'hFFFF_FFF8);
    check_eq("r_imm_pre", {27'd0, bus.id_ex_rd}, 32'd1);

    // 4: load-use stall lasts one cycle
    drive(32'd32, enc_lw(5'd5, 5'd1));
    check_eq("lw_nohaz", {31'd0, bus.hazard}, 32'd0);
    step();
    check_eq("lw_a", bus.id_ex_a, 32'd5);
    drive(32'd36, enc_r(5'd6, 5'd5, 5'd5));
    check_eq("lu_hazard", {31'd0, bus.hazard}, 32'd1);
    step();
    check_eq("lu_bub_valid", {31'd0, bus.id_ex_valid}, 32'd0);
    check_eq("lu_bub_ir", bus.id_ex_ir, 32'h13);
    check_eq("lu_bub_rd", {27'd0, bus.id_ex_rd}, 32'd0);
    check_eq("lu_hazard_gone", {31'd0, bus.hazard}, 32'd0);
    step();
    check_eq("lu_add_valid", {31'd0, bus.id_ex_valid}, 32'd1);
    check_eq("lu_add_rd", {27'd0, bus.id_ex_rd}, 32'd6);
    check_eq("lu_add_ir", bus.id_ex_ir, enc_r(5'd6, 5'd5, 5'd5));

    // 5: flush beats hazard
    drive(32'd40, enc_lw(5'd5, 5'd1));
    step();
    bus.branch_cond = 1'b1;
    drive(32'd44, enc_r(5'd6, 5'd5, 5'd5));
    check_eq("fl_hazard", {31'd0, bus.hazard}, 32'd0);
    step();
    bus.branch_cond = 1'b0;
    check_eq("fl_valid", {31'd0, bus.id_ex_valid}, 32'd0);
    check_eq("fl_ir", bus.id_ex_ir, 32'h13);
    check_eq("fl_npc", bus.id_ex_npc, 32'd0);
    drive(32'd4, 32'h00A0_8113);
    step();
    check_eq("fl_next_valid", {31'd0, bus.id_ex_valid}, 32'd1);

    // 6: x0 writes discarded
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    drive(32'd48, enc_r(5'd8, 5'd0, 5'd0));
    step();
    check_eq("x0_byp_a", bus.id_ex_a, 32'd0);
    bus.wb_we = 1'b0;
    step();
    check_eq("x0_a", bus.id_ex_a, 32'd0);
    check_eq("x0_b", bus.id_ex_b, 32'd0);

    // Reset mid-stall
    drive(32'd52, enc_lw(5'd5, 5'd1));
    step();
    drive(32'd56, enc_r(5'd6, 5'd1, 5'd5));
    check_eq("ms_hazard", {31'd0, bus.hazard}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("ms_rst_hazard", {31'd0, bus.hazard}, 32'd0);
    check_eq("ms_rst_valid", {31'd0, bus.id_ex_valid}, 32'd0);
    step();
    reset = 1'b1;
    #1;
    check_eq("ms_rel_hazard", {31'd0, bus.hazard}, 32'd0);
    step();
    check_eq("ms_valid", {31'd0, bus.id_ex_valid}, 32'd1);
    check_eq("ms_rd", {27'd0, bus.id_ex_rd}, 32'd6);
    check_eq("ms_npc", bus.id_ex_npc, 32'd56);
    check_eq("ms_a_cleared", bus.id_ex_a, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
